// File: rtl/mc_package.sv
// Shared memory-controller bus widths used by the arbiter and its requesters.
package mc_package;
    parameter int ADDRWIDTH = 16;
    parameter int DATAWIDTH = 32;
endpackage

// File: rtl/mc_arbiter_if.sv
// Requester-side and memory-controller-side signals of mc_arbiter.
interface mc_arbiter_if #(parameter int NUM_REQ = 4);
    import mc_package::*;

    logic [NUM_REQ-1:0]                req_valid;
    logic [NUM_REQ-1:0]                req_rd_wr;
    logic [NUM_REQ-1:0][ADDRWIDTH-1:0] req_addr;
    logic [NUM_REQ-1:0][DATAWIDTH-1:0] req_wr_data;
    logic [NUM_REQ-1:0]                req_ready;
    logic [DATAWIDTH-1:0]              req_rd_data;
    logic [NUM_REQ-1:0]                grant;
    logic                              timeout;

    logic [ADDRWIDTH-1:0]              mc_addr;
    logic [DATAWIDTH-1:0]              mc_wr_data;
    logic                              mc_rd_wr;
    logic                              mc_valid;
    logic [DATAWIDTH-1:0]              mc_rd_data;
    logic                              mc_ready;

    modport slave (
        input  req_valid, req_rd_wr, req_addr, req_wr_data, mc_rd_data, mc_ready,
        output req_ready, req_rd_data, grant, timeout, mc_addr, mc_wr_data, mc_rd_wr, mc_valid
    );

    modport master (
        output req_valid, req_rd_wr, req_addr, req_wr_data, mc_rd_data, mc_ready,
        input  req_ready, req_rd_data, grant, timeout, mc_addr, mc_wr_data, mc_rd_wr, mc_valid
    );
endinterface

// File: rtl/mc_arbiter.sv
// Round-robin arbiter sharing one memory controller among NUM_REQ requesters.
// Optional BUSY watchdog is enabled with macro MC_ARB_TIMEOUT_EN.
module mc_arbiter
    import mc_package::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    mc_arbiter_if.slave  bus,
    output logic [1:0]   state_o
);
    // Handshake: a request is held on mc_valid/mc_addr/mc_wr_data/mc_rd_wr until the
    // controller answers with mc_ready for one cycle; that same cycle req_ready pulses
    // for the granted requester only, and req_rd_data is meaningful only then.
    localparam int IDXW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RELEASE = 2'd2} state_e;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("mc_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
    end

    state_e                 state_q, state_d;
    logic [IDXW-1:0]        rr_q, rr_d, gnt_idx_q, gnt_idx_d, win_idx;
    logic [IDXW:0]          cand;
    logic                   win_found;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic                   valid_q, valid_d, rd_wr_q, rd_wr_d;
    logic [ADDRWIDTH-1:0]   addr_q, addr_d;
    logic [DATAWIDTH-1:0]   wdata_q, wdata_d;
    logic                   done, tmo_hit;

    // First requesting port at or above the rr pointer, wrapping to 0.
    always_comb begin
        win_idx   = '0;
        win_found = 1'b0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = {1'b0, rr_q} + (IDXW+1)'(i);
            if (cand >= (IDXW+1)'(NUM_REQ)) cand = cand - (IDXW+1)'(NUM_REQ);
            if (!win_found && bus.req_valid[cand[IDXW-1:0]]) begin
                win_found = 1'b1;
                win_idx   = cand[IDXW-1:0];
            end
        end
    end

`ifdef MC_ARB_TIMEOUT_EN
    localparam int WDW = $clog2(TIMEOUT_CYCLES + 1);
    logic [WDW-1:0] wdog_q, wdog_d;

    always_comb begin
        wdog_d  = (state_q == BUSY) ? wdog_q + WDW'(1) : '0;
        tmo_hit = (state_q == BUSY) && (wdog_q == WDW'(TIMEOUT_CYCLES - 1)) && !bus.mc_ready;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) wdog_q <= '0;
        else       wdog_q <= wdog_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    assign done = (state_q == BUSY) && (bus.mc_ready || tmo_hit);

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        gnt_idx_d = gnt_idx_q;
        grant_d   = grant_q;
        valid_d   = valid_q;
        rd_wr_d   = rd_wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    gnt_idx_d          = win_idx;
                    grant_d            = '0;
                    grant_d[win_idx]   = 1'b1;
                    valid_d            = 1'b1;
                    rd_wr_d            = bus.req_rd_wr[win_idx];
                    addr_d             = bus.req_addr[win_idx];
                    // Reads keep the previous write data on the bus.
                    if (bus.req_rd_wr[win_idx]) wdata_d = bus.req_wr_data[win_idx];
                    state_d            = BUSY;
                end
            end
            BUSY: begin
                if (done) begin
                    valid_d = 1'b0;
                    grant_d = '0;
                    rr_d    = (gnt_idx_q == IDXW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IDXW'(1);
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            gnt_idx_q <= '0;
            grant_q   <= '0;
            valid_q   <= 1'b0;
            rd_wr_q   <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            gnt_idx_q <= gnt_idx_d;
            grant_q   <= grant_d;
            valid_q   <= valid_d;
            rd_wr_q   <= rd_wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
        end
    end

    assign bus.req_ready   = done ? grant_q : '0;
    assign bus.req_rd_data = bus.mc_rd_data;
    assign bus.grant       = grant_q;
    assign bus.timeout     = tmo_hit;
    assign bus.mc_addr     = addr_q;
    assign bus.mc_wr_data  = wdata_q;
    assign bus.mc_rd_wr    = rd_wr_q;
    assign bus.mc_valid    = valid_q;
    assign state_o         = state_q;
endmodule

// File: doc/mc_arbiter.md
MC_ARBITER -- requirements
Module: mc_arbiter

Interface
REQ-001 Parameter: NUM_REQ, default 4, number of requester ports (2..8); ADDRWIDTH and DATAWIDTH SHALL come from mc_package.
REQ-002 Parameter: TIMEOUT_CYCLES, default 64, watchdog limit in Clock cycles (used only with MC_ARB_TIMEOUT_EN).
REQ-003 Clock  in  1  single clock; all state changes on posedge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 Req_valid  in  NUM_REQ  per-requester request strobe.
REQ-006 Req_Rd_Wr  in  NUM_REQ  per-requester operation: 0=read, 1=write.
REQ-007 Req_Addr  in  NUM_REQ x ADDRWIDTH  per-requester address.
REQ-008 Req_WrData  in  NUM_REQ x DATAWIDTH  per-requester write data.
REQ-009 Req_Ready  out  NUM_REQ  per-requester completion pulse.
REQ-010 Req_RdData  out  DATAWIDTH  read data broadcast to all requesters; valid only with a Req_Ready pulse.
REQ-011 Grant  out  NUM_REQ  one-hot owner of the memory controller; all-zero when idle.
REQ-012 Timeout  out  1  abort flag qualifying Req_Ready.
REQ-013 Addr / WrData / Rd_Wr / valid  out  ADDRWIDTH / DATAWIDTH / 1 / 1  request to memory controller.
REQ-014 RdData / Ready  in  DATAWIDTH / 1  response from memory controller.

Function
REQ-015 FSM states SHALL be IDLE, BUSY, RELEASE.
REQ-016 IDLE: if any Req_valid is high, winner = first requester with Req_valid high, searching upward from the rr pointer and wrapping at NUM_REQ-1 to 0.
REQ-017 On that edge: winner's Addr/WrData/Rd_Wr latched, Grant set, go to BUSY; valid=1 from the next cycle (1-cycle issue latency).
REQ-018 BUSY: valid, Addr, WrData, Rd_Wr held constant from the latched copy; requester inputs ignored, dropping Req_valid does not cancel.
REQ-019 BUSY with Ready=1: Req_Ready[granted]=Ready combinationally in the same cycle; Req_RdData=RdData for reads.
REQ-019 (cont.) On that edge: valid drops, rr pointer = granted+1 (mod NUM_REQ), go to RELEASE.
REQ-020 RELEASE: one cycle with valid=0, Grant=0 and all Req_valid ignored so the completed requester can drop its strobe; then go to IDLE.
REQ-021 Back-to-back throughput SHALL be one transaction per 3 cycles plus controller latency; no requester waits more than NUM_REQ-1 other grants.
REQ-022 Req_Ready SHALL never assert for a non-granted requester; Ready seen in IDLE or RELEASE SHALL be ignored.
REQ-023 Rd_Wr=0 transactions SHALL leave WrData at its last value; Req_RdData SHALL be don't-care outside Req_Ready.

Reset
REQ-024 Reset SHALL force, asynchronously: state IDLE, valid=0, Grant=0, Req_Ready=0, Timeout=0, Addr=0, WrData=0, Rd_Wr=0, rr pointer=0, watchdog=0.
REQ-025 Reset during BUSY SHALL abandon the transaction without a Req_Ready pulse; the first grant after release SHALL go to requester 0 if it is requesting.

Configuration
REQ-026 Macro MC_ARB_TIMEOUT_EN defined: watchdog counts BUSY cycles.
REQ-026 (cont.) On the TIMEOUT_CYCLES-th cycle without Ready: Req_Ready[granted]=1 and Timeout=1 for one cycle, valid drops, pointer advances, go to RELEASE.
REQ-026 (cont.) Ready arriving on that same cycle wins: normal completion, Timeout=0.
REQ-027 Macro undefined: no watchdog logic; Timeout tied 0; BUSY waits indefinitely for Ready.

Verification
REQ-028 Single read: Req_valid[1]=1, Rd_Wr=0, Addr=0x10, controller Ready after 3 cycles with RdData=0xA5 -> valid high 1 cycle after request, Req_Ready[1] pulses with Req_RdData=0xA5, Grant=0010 during BUSY.
REQ-029 Round robin: all 4 Req_valid held high, writes -> grant order 0,1,2,3,0; each Grant one-hot; WrData matches the granted requester.
REQ-030 Input change mid-flight: requester 2 changes Req_Addr 0x20->0x30 and drops Req_valid during BUSY -> Addr stays 0x20 until Ready; Req_Ready[2] still pulses.
REQ-031 Reset mid-operation: Reset asserted in BUSY -> valid and Grant 0 immediately without a clock; no Req_Ready; next grant goes to requester 0.
REQ-032 Spurious Ready: Ready=1 while IDLE -> no Req_Ready, no state change.
REQ-033 With MC_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, Ready never asserted -> at BUSY cycle 8 Req_Ready[g]=1 and Timeout=1; next requester then served normally.
